// File: rtl/lbp_pkg.sv
// Shared geometry, FSM state type and pixel-address helpers for the LBP host.
package lbp_pkg;

    localparam int IMG_W  = 128;
    localparam int IMG_H  = 128;
    localparam int ADDR_W = 14;

    // Address split: low bits are x, high bits are y (IMG_W is a power of two).
    localparam int X_W = $clog2(IMG_W);
    localparam int Y_W = ADDR_W - X_W;

    localparam logic [X_W-1:0] X_MAX = X_W'(IMG_W - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(IMG_H - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_e;

    function automatic logic [X_W-1:0] pix_x(input logic [ADDR_W-1:0] addr);
        return addr[X_W-1:0];
    endfunction

    function automatic logic [Y_W-1:0] pix_y(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:X_W];
    endfunction

    // True when the pixel sits on the outer ring of the image, where no
    // 3x3 neighbourhood exists and the engine should never write a result.
    function automatic logic is_border(input logic [ADDR_W-1:0] addr);
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        x = pix_x(addr);
        y = pix_y(addr);
        return (x == '0) || (x == X_MAX) || (y == '0) || (y == Y_MAX);
    endfunction

endpackage

// File: rtl/lbp_host_ram.sv
// 2^AW x DW memory with one synchronous write port and one read port.
// RD_REG=0 gives a combinational read, RD_REG=1 a registered read that
// clears on reset (the memory array itself is never reset).
module lbp_host_ram #(
    parameter int AW     = 14,
    parameter int DW     = 8,
    parameter bit RD_REG = 1'b0
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];

    // Synchronous write port.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    generate
        if (RD_REG) begin : g_reg_rd
            logic [DW-1:0] r_rd_data;

            // Registered read, one cycle latency; read-before-write on collision.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_rd_data <= '0;
                end else begin
                    r_rd_data <= r_mem[i_rd_addr];
                end
            end

            assign o_rd_data = r_rd_data;
        end else begin : g_comb_rd
            logic w_unused_rst;
            assign w_unused_rst = i_rst_n;
            assign o_rd_data    = r_mem[i_rd_addr];
        end
    endgenerate

endmodule

// File: rtl/lbp_host.sv
// LBP host: serves the gray image to the LBP engine, captures its results,
// and reports status (done / timeout / border-write / count / checksum).
// Optional macro LBP_HOST_BORDER_CHK_EN enables the border-write detector;
// without it addr_err is constant 0.
module lbp_host
    import lbp_pkg::*;
#(
    parameter int TO_W    = 20,
    parameter int TIMEOUT = 500000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              img_wr_en,
    input  logic [ADDR_W-1:0] img_wr_addr,
    input  logic [7:0]        img_wr_data,
    input  logic              start,
    output logic              gray_ready,
    input  logic              gray_req,
    input  logic [ADDR_W-1:0] gray_addr,
    output logic [7:0]        gray_data,
    input  logic              lbp_valid,
    input  logic [ADDR_W-1:0] lbp_addr,
    input  logic [7:0]        lbp_data,
    input  logic              finish,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              done,
    output logic              timeout_err,
    output logic              addr_err,
    output logic [ADDR_W:0]   wr_count,
    output logic [15:0]       checksum
);

    localparam logic [TO_W-1:0] WDOG_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [ADDR_W:0] WR_MAX    = {1'b1, {ADDR_W{1'b0}}};

    state_e              r_state;
    state_e              w_state_next;
    logic                w_run_enter;
    logic                w_in_run;
    logic                w_capture;
    logic                w_new_wr;
    logic [TO_W-1:0]     r_wdog;
    logic [ADDR_W-1:0]   r_last_addr;
    logic                r_have_last;
    logic [ADDR_W:0]     r_wr_count;
    logic [15:0]         r_checksum;
    logic [7:0]          w_img_rd;
    logic                w_img_we;

    assign w_in_run  = (r_state == RUN);
    assign w_capture = w_in_run && lbp_valid;
    assign w_new_wr  = w_capture && (!r_have_last || (lbp_addr != r_last_addr));
    assign w_img_we  = img_wr_en && (r_state == IDLE);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; finish wins over a simultaneous watchdog expiry.
    always_comb begin
        w_state_next = r_state;
        w_run_enter  = 1'b0;
        case (r_state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    w_state_next = RUN;
                    w_run_enter  = 1'b1;
                end
            end
            RUN: begin
                if (finish) begin
                    w_state_next = DONE;
                end else if (r_wdog == WDOG_LAST) begin
                    w_state_next = ERR;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Watchdog: counts RUN cycles, restarts on every entry into RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wdog <= '0;
        end else if (w_run_enter) begin
            r_wdog <= '0;
        end else if (w_in_run) begin
            r_wdog <= r_wdog + 1'b1;
        end
    end

    // Result bookkeeping: only address changes count as new writes, so an
    // engine holding lbp_valid on one address is counted once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_addr <= '0;
            r_have_last <= 1'b0;
            r_wr_count  <= '0;
            r_checksum  <= '0;
        end else if (w_run_enter) begin
            r_last_addr <= '0;
            r_have_last <= 1'b0;
            r_wr_count  <= '0;
            r_checksum  <= '0;
        end else if (w_new_wr) begin
            r_last_addr <= lbp_addr;
            r_have_last <= 1'b1;
            r_checksum  <= r_checksum + {8'd0, lbp_data};
            if (r_wr_count != WR_MAX) begin
                r_wr_count <= r_wr_count + 1'b1;
            end
        end
    end

`ifdef LBP_HOST_BORDER_CHK_EN
    logic r_addr_err;

    // Sticky border-write flag, cleared only when a new run starts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr_err <= 1'b0;
        end else if (w_run_enter) begin
            r_addr_err <= 1'b0;
        end else if (w_new_wr && is_border(lbp_addr)) begin
            r_addr_err <= 1'b1;
        end
    end

    assign addr_err = r_addr_err;
`else
    assign addr_err = 1'b0;
`endif

    // Image RAM: preload in IDLE, combinational read toward the engine.
    lbp_host_ram #(
        .AW     (ADDR_W),
        .DW     (8),
        .RD_REG (1'b0)
    ) u_img_ram (
        .i_clk     (clk),
        .i_rst_n   (reset),
        .i_we      (w_img_we),
        .i_wr_addr (img_wr_addr),
        .i_wr_data (img_wr_data),
        .i_rd_addr (gray_addr),
        .o_rd_data (w_img_rd)
    );

    // Result RAM: every captured strobe writes, registered readback port.
    lbp_host_ram #(
        .AW     (ADDR_W),
        .DW     (8),
        .RD_REG (1'b1)
    ) u_res_ram (
        .i_clk     (clk),
        .i_rst_n   (reset),
        .i_we      (w_capture),
        .i_wr_addr (lbp_addr),
        .i_wr_data (lbp_data),
        .i_rd_addr (rd_addr),
        .o_rd_data (rd_data)
    );

    assign gray_data   = (gray_req && w_in_run) ? w_img_rd : 8'd0;
    assign gray_ready  = w_in_run;
    assign done        = (r_state == DONE);
    assign timeout_err = (r_state == ERR);
    assign wr_count    = r_wr_count;
    assign checksum    = r_checksum;

endmodule

// File: tb/tb_lbp_host.sv
// Directed scoreboard bench for lbp_host: stimulus pushes expected output
// values tagged with the cycle they must hold in; a monitor checks them on
// the falling edge.
module tb_lbp_host;
    import lbp_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              img_wr_en;
    logic [ADDR_W-1:0] img_wr_addr;
    logic [7:0]        img_wr_data;
    logic              start;
    logic              gray_ready;
    logic              gray_req;
    logic [ADDR_W-1:0] gray_addr;
    logic [7:0]        gray_data;
    logic              lbp_valid;
    logic [ADDR_W-1:0] lbp_addr;
    logic [7:0]        lbp_data;
    logic              finish;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              done;
    logic              timeout_err;
    logic              addr_err;
    logic [ADDR_W:0]   wr_count;
    logic [15:0]       checksum;

`ifdef LBP_HOST_BORDER_CHK_EN
    localparam logic [31:0] BORDER_EXP = 32'd1;
`else
    localparam logic [31:0] BORDER_EXP = 32'd0;
`endif

    lbp_host #(
        .TO_W    (20),
        .TIMEOUT (100)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .img_wr_en   (img_wr_en),
        .img_wr_addr (img_wr_addr),
        .img_wr_data (img_wr_data),
        .start       (start),
        .gray_ready  (gray_ready),
        .gray_req    (gray_req),
        .gray_addr   (gray_addr),
        .gray_data   (gray_data),
        .lbp_valid   (lbp_valid),
        .lbp_addr    (lbp_addr),
        .lbp_data    (lbp_data),
        .finish      (finish),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .done        (done),
        .timeout_err (timeout_err),
        .addr_err    (addr_err),
        .wr_count    (wr_count),
        .checksum    (checksum)
    );

    always #5 clk = ~clk;

    typedef enum int {S_GREADY, S_GDATA, S_RDDATA, S_DONE, S_TOERR, S_AERR, S_WRCNT, S_CSUM} sel_e;
    typedef struct {
        int          cyc;
        sel_e        sel;
        logic [31:0] val;
        int          step;
    } exp_t;

    exp_t sb_q[$];
    int   cyc_cnt = 0;
    int   step    = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic string sel_name(sel_e s);
        case (s)
            S_GREADY: return "gray_ready";
            S_GDATA:  return "gray_data";
            S_RDDATA: return "rd_data";
            S_DONE:   return "done";
            S_TOERR:  return "timeout_err";
            S_AERR:   return "addr_err";
            S_WRCNT:  return "wr_count";
            S_CSUM:   return "checksum";
            default:  return "unknown";
        endcase
    endfunction

    function automatic logic [31:0] act_of(sel_e s);
        case (s)
            S_GREADY: return {31'd0, gray_ready};
            S_GDATA:  return {24'd0, gray_data};
            S_RDDATA: return {24'd0, rd_data};
            S_DONE:   return {31'd0, done};
            S_TOERR:  return {31'd0, timeout_err};
            S_AERR:   return {31'd0, addr_err};
            S_WRCNT:  return {17'd0, wr_count};
            S_CSUM:   return {16'd0, checksum};
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: pop every expectation due this cycle and compare.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] a;
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc_cnt) begin
            e = sb_q.pop_front();
            a = act_of(e.sel);
            n_tests = n_tests + 1;
            if (a !== e.val) begin
                n_fail = n_fail + 1;
                $display("[TB] FAIL step%0d %s: got 0x%0h, expected 0x%0h",
                         e.step, sel_name(e.sel), a, e.val);
            end else begin
                $display("[TB] ok   step%0d %s = 0x%0h", e.step, sel_name(e.sel), a);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input sel_e s, input logic [31:0] v);
        exp_t e;
        e.cyc  = cyc_cnt;
        e.sel  = s;
        e.val  = v;
        e.step = step;
        sb_q.push_back(e);
    endtask

    task automatic expect_reset_state();
        expect_out(S_GREADY, 0);
        expect_out(S_GDATA, 0);
        expect_out(S_RDDATA, 0);
        expect_out(S_DONE, 0);
        expect_out(S_TOERR, 0);
        expect_out(S_AERR, 0);
        expect_out(S_WRCNT, 0);
        expect_out(S_CSUM, 0);
    endtask

    task automatic wr_img(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        img_wr_en   = 1'b1;
        img_wr_addr = a;
        img_wr_data = d;
        tick();
        img_wr_en   = 1'b0;
    endtask

    task automatic capture(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        lbp_valid = 1'b1;
        lbp_addr  = a;
        lbp_data  = d;
        tick();
        lbp_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b0; img_wr_en = 1'b0; img_wr_addr = '0; img_wr_data = '0;
        start = 1'b0; gray_req = 1'b0; gray_addr = '0; lbp_valid = 1'b0;
        lbp_addr = '0; lbp_data = '0; finish = 1'b0; rd_addr = '0;

        // Reset values
        step = 0;
        tick(); tick();
        expect_reset_state();
        tick();
        reset = 1'b1;
        tick();

        // Preload centre pixel and its neighbours, read in IDLE (must be 0)
        step = 1;
        wr_img(14'h0081, 8'd50);
        wr_img(14'h0000, 8'd60); wr_img(14'h0001, 8'd60); wr_img(14'h0002, 8'd60);
        wr_img(14'h0080, 8'd60); wr_img(14'h0082, 8'd60);
        wr_img(14'h0100, 8'd60); wr_img(14'h0101, 8'd60); wr_img(14'h0102, 8'd60);
        gray_req = 1'b1; gray_addr = 14'h0080;
        expect_out(S_GDATA, 0);
        expect_out(S_GREADY, 0);
        pulse_start();

        // Zero-latency gray reads in RUN
        step = 2;
        expect_out(S_GDATA, 60);
        expect_out(S_GREADY, 1);
        tick();
        gray_addr = 14'h0081;
        expect_out(S_GDATA, 50);
        tick();
        gray_req = 1'b0;
        expect_out(S_GDATA, 0);
        wr_img(14'h0080, 8'd99);       // ignored in RUN
        gray_req = 1'b1; gray_addr = 14'h0080;
        expect_out(S_GDATA, 60);
        tick();
        gray_req = 1'b0;

        // Held strobe on one address counts once
        step = 3;
        lbp_valid = 1'b1; lbp_addr = 14'h0081; lbp_data = 8'hFF;
        repeat (5) tick();
        lbp_valid = 1'b0;
        expect_out(S_WRCNT, 1);
        expect_out(S_CSUM, 16'h00FF);
        rd_addr = 14'h0081;
        tick();
        expect_out(S_RDDATA, 8'hFF);
        capture(14'h0081, 8'hAA);      // same address, new data: RAM only
        expect_out(S_WRCNT, 1);
        expect_out(S_CSUM, 16'h00FF);
        tick();
        expect_out(S_RDDATA, 8'hAA);

        // finish -> DONE
        step = 4;
        finish = 1'b1;
        tick();
        finish = 1'b0;
        expect_out(S_DONE, 1);
        expect_out(S_GREADY, 0);
        expect_out(S_WRCNT, 1);

        // New run: three captures, last one with finish
        step = 5;
        pulse_start();
        expect_out(S_DONE, 0);
        expect_out(S_WRCNT, 0);
        expect_out(S_CSUM, 0);
        expect_out(S_GREADY, 1);
        capture(14'h0081, 8'h10);
        capture(14'h0082, 8'h20);
        finish = 1'b1;
        capture(14'h0083, 8'h30);
        finish = 1'b0;
        expect_out(S_DONE, 1);
        expect_out(S_GREADY, 0);
        expect_out(S_WRCNT, 3);
        expect_out(S_CSUM, 16'h0060);
        expect_out(S_AERR, 0);
        rd_addr = 14'h0083;
        tick();
        expect_out(S_RDDATA, 8'h30);

        // Border write at pixel 0
        step = 6;
        pulse_start();
        capture(14'h0000, 8'h05);
        expect_out(S_AERR, BORDER_EXP);
        expect_out(S_WRCNT, 1);
        expect_out(S_CSUM, 16'h0005);
        finish = 1'b1;
        tick();
        finish = 1'b0;
        expect_out(S_AERR, BORDER_EXP);   // sticky into DONE

        // Watchdog: 100 RUN cycles then ERR
        step = 7;
        pulse_start();
        expect_out(S_AERR, 0);
        expect_out(S_TOERR, 0);
        repeat (99) tick();
        expect_out(S_GREADY, 1);
        expect_out(S_TOERR, 0);
        tick();
        expect_out(S_TOERR, 1);
        expect_out(S_GREADY, 0);
        expect_out(S_DONE, 0);
        pulse_start();
        expect_out(S_TOERR, 0);
        expect_out(S_GREADY, 1);
        capture(14'h017F, 8'h01);       // x = IMG_W-1
        expect_out(S_AERR, BORDER_EXP);
        expect_out(S_WRCNT, 1);

        // Reset mid-run
        step = 8;
        tick();
        reset = 1'b0;
        gray_req = 1'b1; gray_addr = 14'h0081;
        expect_reset_state();
        tick();
        reset = 1'b1;
        tick();
        wr_img(14'h0005, 8'd77);
        pulse_start();
        gray_addr = 14'h0005;
        expect_out(S_GDATA, 77);
        expect_out(S_GREADY, 1);
        tick();
        gray_req = 1'b0;
        tick();

        if (sb_q.size() != 0) begin
            n_fail = n_fail + 1;
            $display("[TB] FAIL drain: got %0d pending, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
